// File: rtl/imem_loader.sv
// imem_loader: byte-addressed instruction store filled at run time from a
// valid/ready word stream. Words land big-endian, four bytes at a time, and
// the processor is held until a full program has been accepted.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | just out of reset, not yet accepting words
// S_LOAD  | accepting words, processor held
// S_DONE  | program complete, processor running, fetch enabled
// S_ERROR | more words offered than fit, processor held until reload
module imem_loader #(
    parameter int DEPTH_BYTES = 404,
    parameter int AW          = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic          reload,
    input  logic [31:0]   address,
    output logic [31:0]   instruction,
    output logic          cpu_hold,
    output logic          load_error,
    output logic [AW-2:0] word_count
);

    // Index width sized to the array itself so every array access uses the
    // natural index width regardless of how generous AW is.
    localparam int IW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [AW-1:0] DEPTH_PTR = AW'(DEPTH_BYTES);
    localparam logic [32:0]   DEPTH_33  = 33'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-2:0] word_count_q, word_count_d;
    logic          load_ready_q, load_ready_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          load_error_q, load_error_d;

    logic [7:0]    mem_q [DEPTH_BYTES];

    logic          wr_en;
    logic [AW-1:0] wr_ptr_inc;
    logic [IW-1:0] wr_idx0, wr_idx1, wr_idx2, wr_idx3;

    logic [32:0]   rd_end;
    logic          rd_in_range;
    logic [IW-1:0] rd_idx0, rd_idx1, rd_idx2, rd_idx3;

    // load_ready_q is high exactly while loading, so it doubles as the
    // handshake qualifier.
    assign wr_en      = load_ready_q && load_valid;
    assign wr_ptr_inc = wr_ptr_q + AW'(4);

    // While loading the pointer never exceeds DEPTH_BYTES-4, so ptr+3 fits IW.
    assign wr_idx0 = wr_ptr_q[IW-1:0];
    assign wr_idx1 = wr_ptr_q[IW-1:0] + IW'(1);
    assign wr_idx2 = wr_ptr_q[IW-1:0] + IW'(2);
    assign wr_idx3 = wr_ptr_q[IW-1:0] + IW'(3);

    // Range check is done on 33 bits so addresses near 2^32 cannot wrap in.
    assign rd_end      = {1'b0, address} + 33'd3;
    assign rd_in_range = (rd_end < DEPTH_33);

    // Indices may alias when out of range; those reads are masked below.
    assign rd_idx0 = address[IW-1:0];
    assign rd_idx1 = address[IW-1:0] + IW'(1);
    assign rd_idx2 = address[IW-1:0] + IW'(2);
    assign rd_idx3 = address[IW-1:0] + IW'(3);

    // Next-state, pointer and registered-output logic.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        load_ready_d = load_ready_q;
        cpu_hold_d   = cpu_hold_q;
        load_error_d = load_error_q;

        case (state_q)
            S_IDLE: begin
                state_d      = S_LOAD;
                load_ready_d = 1'b1;
                cpu_hold_d   = 1'b1;
                load_error_d = 1'b0;
            end

            S_LOAD: begin
                if (wr_en) begin
                    wr_ptr_d     = wr_ptr_inc;
                    word_count_d = word_count_q + (AW-1)'(1);
                    if (load_last) begin
                        // Last word wins over overflow: a full store is fine.
                        state_d      = S_DONE;
                        load_ready_d = 1'b0;
                        cpu_hold_d   = 1'b0;
                    end else if (wr_ptr_inc == DEPTH_PTR) begin
                        state_d      = S_ERROR;
                        load_ready_d = 1'b0;
                        load_error_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                if (reload) begin
                    state_d      = S_LOAD;
                    wr_ptr_d     = '0;
                    word_count_d = '0;
                    load_ready_d = 1'b1;
                    cpu_hold_d   = 1'b1;
                end
            end

            S_ERROR: begin
                if (reload) begin
                    state_d      = S_LOAD;
                    wr_ptr_d     = '0;
                    word_count_d = '0;
                    load_ready_d = 1'b1;
                    cpu_hold_d   = 1'b1;
                    load_error_d = 1'b0;
                end
            end

            default: begin
                state_d      = S_IDLE;
                wr_ptr_d     = '0;
                word_count_d = '0;
                load_ready_d = 1'b0;
                cpu_hold_d   = 1'b1;
                load_error_d = 1'b0;
            end
        endcase
    end

    // State, pointer and flag registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            load_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            load_ready_q <= load_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            load_error_q <= load_error_d;
        end
    end

    // Byte store write, big-endian; contents survive reset and reload.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx0] <= load_data[31:24];
            mem_q[wr_idx1] <= load_data[23:16];
            mem_q[wr_idx2] <= load_data[15:8];
            mem_q[wr_idx3] <= load_data[7:0];
        end
    end

    // Combinational fetch, forced to zero while held or past the end.
    always_comb begin
        instruction = 32'd0;
        if (!cpu_hold_q && rd_in_range) begin
            instruction = {mem_q[rd_idx0], mem_q[rd_idx1], mem_q[rd_idx2], mem_q[rd_idx3]};
        end
    end

    assign load_ready = load_ready_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_error = load_error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed vector table, hand-written corner sequences,
// and randomized traffic against a word-level reference model. Two instances:
// the default 404-byte store and an 8-byte store for overflow behaviour.
module tb_imem_loader;

    logic        clock;
    logic        reset;

    logic        a_valid, a_last, a_reload, a_ready, a_hold, a_err;
    logic [31:0] a_data, a_addr, a_instr;
    logic [7:0]  a_wc;

    logic        b_valid, b_last, b_reload, b_ready, b_hold, b_err;
    logic [31:0] b_data, b_addr, b_instr;
    logic [2:0]  b_wc;

    int n_pass  = 0;
    int n_total = 0;

    imem_loader dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (a_valid),
        .load_data   (a_data),
        .load_last   (a_last),
        .load_ready  (a_ready),
        .reload      (a_reload),
        .address     (a_addr),
        .instruction (a_instr),
        .cpu_hold    (a_hold),
        .load_error  (a_err),
        .word_count  (a_wc)
    );

    imem_loader #(.DEPTH_BYTES(8), .AW(4)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (b_valid),
        .load_data   (b_data),
        .load_last   (b_last),
        .load_ready  (b_ready),
        .reload      (b_reload),
        .address     (b_addr),
        .instruction (b_instr),
        .cpu_hold    (b_hold),
        .load_error  (b_err),
        .word_count  (b_wc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic l);
        a_valid = 1'b1;
        a_data  = d;
        a_last  = l;
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic l);
        b_valid = 1'b1;
        b_data  = d;
        b_last  = l;
        tick();
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    // ---------------- reference model (word-level view) ----------------
    int         depth [2] = '{404, 8};
    bit         m_started [2];
    bit         m_done [2];
    bit         m_err [2];
    int         m_words [2];
    logic [7:0] m_mem [2][404];
    bit         m_wr [2][404];

    task automatic model_reset(input int u);
        m_started[u] = 0;
        m_done[u]    = 0;
        m_err[u]     = 0;
        m_words[u]   = 0;
    endtask

    function automatic bit m_loading(input int u);
        return m_started[u] && !m_done[u] && !m_err[u];
    endfunction

    // Effect of one rising edge given the inputs presented before it.
    task automatic model_edge(input int u, input logic v, input logic [31:0] d,
                              input logic l, input logic r);
        int base;
        if (!m_started[u]) begin
            m_started[u] = 1;
        end else if (m_loading(u)) begin
            if (v) begin
                base = 4 * m_words[u];
                for (int k = 0; k < 4; k++) begin
                    m_mem[u][base + k] = d[31 - 8*k -: 8];
                    m_wr[u][base + k]  = 1;
                end
                m_words[u]++;
                if (l) m_done[u] = 1;
                else if (4 * m_words[u] == depth[u]) m_err[u] = 1;
            end
        end else if (r) begin
            m_done[u]  = 0;
            m_err[u]   = 0;
            m_words[u] = 0;
        end
    endtask

    task automatic model_compare(input int u, input logic [31:0] addr,
                                 input logic rdy, input logic hld, input logic er,
                                 input logic [31:0] wc, input logic [31:0] ins);
        longint a3;
        bit     known;
        logic [31:0] e;
        chk("rnd_ready", {31'd0, rdy}, {31'd0, m_loading(u)});
        chk("rnd_hold",  {31'd0, hld}, {31'd0, !m_done[u]});
        chk("rnd_error", {31'd0, er},  {31'd0, m_err[u]});
        chk("rnd_count", wc, 32'(m_words[u]));
        a3 = longint'(addr) + 3;
        if (!m_done[u] || a3 >= longint'(depth[u])) begin
            chk("rnd_instr_zero", ins, 32'd0);
        end else begin
            known = 1;
            for (int k = 0; k < 4; k++)
                if (!m_wr[u][int'(addr) + k]) known = 0;
            if (known) begin
                for (int k = 0; k < 4; k++)
                    e[31 - 8*k -: 8] = m_mem[u][int'(addr) + k];
                chk("rnd_instr", ins, e);
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        rel;
        logic [31:0] addr;
        logic        e_ready;
        logic        e_hold;
        logic        e_err;
        logic [7:0]  e_wc;
        logic [31:0] e_instr;
        logic        chk_instr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 32'h80010605, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 1'b0, 8'd0, 32'h0,        1'b1};
        tbl[1]  = '{1'b1, 32'h80010605, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 1'b0, 8'd1, 32'h0,        1'b1};
        tbl[2]  = '{1'b1, 32'h04011000, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 1'b0, 8'd2, 32'h0,        1'b1};
        tbl[3]  = '{1'b1, 32'h0C011800, 1'b1, 1'b0, 32'd4,        1'b0, 1'b0, 1'b0, 8'd3, 32'h04011000, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'd1,        1'b0, 1'b0, 1'b0, 8'd3, 32'h01060504, 1'b1};
        tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'd401,      1'b0, 1'b0, 1'b0, 8'd3, 32'h0,        1'b1};
        tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'd8,        1'b0, 1'b0, 1'b0, 8'd3, 32'h0C011800, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 8'd3, 32'h0,        1'b1};
        tbl[8]  = '{1'b1, 32'h12345678, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 8'd3, 32'h80010605, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'd0,        1'b1, 1'b1, 1'b0, 8'd0, 32'h0,        1'b1};
        tbl[10] = '{1'b1, 32'hA8000000, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 8'd1, 32'hA8000000, 1'b1};
        tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'd4,        1'b0, 1'b0, 1'b0, 8'd1, 32'h04011000, 1'b1};
    end

    initial begin
        reset    = 1'b0;
        a_valid  = 1'b0; a_data = '0; a_last = 1'b0; a_reload = 1'b0; a_addr = '0;
        b_valid  = 1'b0; b_data = '0; b_last = 1'b0; b_reload = 1'b0; b_addr = '0;

        // Reset values
        #12;
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_hold",  {31'd0, a_hold},  32'd1);
        chk("rst_error", {31'd0, a_err},   32'd0);
        chk("rst_count", {24'd0, a_wc},    32'd0);
        chk("rst_instr", a_instr,          32'd0);

        @(posedge clock);
        #1;
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            a_valid  = tbl[i].valid;
            a_data   = tbl[i].data;
            a_last   = tbl[i].last;
            a_reload = tbl[i].rel;
            a_addr   = tbl[i].addr;
            tick();
            chk($sformatf("tbl%0d_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].e_ready});
            chk($sformatf("tbl%0d_hold", i),  {31'd0, a_hold},  {31'd0, tbl[i].e_hold});
            chk($sformatf("tbl%0d_error", i), {31'd0, a_err},   {31'd0, tbl[i].e_err});
            chk($sformatf("tbl%0d_count", i), {24'd0, a_wc},    {24'd0, tbl[i].e_wc});
            if (tbl[i].chk_instr)
                chk($sformatf("tbl%0d_instr", i), a_instr, tbl[i].e_instr);
        end
        a_valid = 1'b0; a_last = 1'b0; a_reload = 1'b0;

        // Gapped stream: preload 4 words, then reload and load 3 with gaps
        a_reload = 1'b1; tick(); a_reload = 1'b0;
        send_a(32'h11111111, 1'b0);
        send_a(32'h22222222, 1'b0);
        send_a(32'h33333333, 1'b0);
        send_a(32'h44444444, 1'b1);
        chk("pre_count", {24'd0, a_wc}, 32'd4);
        a_reload = 1'b1; tick(); a_reload = 1'b0;
        for (int w = 0; w < 3; w++) begin
            send_a(32'hAAAA0000 + 32'(w), (w == 2));
            if (w < 2) begin
                for (int g = 0; g < 5; g++) begin
                    tick();
                    chk("gap_count", {24'd0, a_wc}, 32'(w + 1));
                    chk("gap_ready", {31'd0, a_ready}, 32'd1);
                end
            end
        end
        chk("gap_hold",  {31'd0, a_hold}, 32'd0);
        chk("gap_count_final", {24'd0, a_wc}, 32'd3);
        a_addr = 32'd0;  #1; chk("gap_w0", a_instr, 32'hAAAA0000);
        a_addr = 32'd4;  #1; chk("gap_w1", a_instr, 32'hAAAA0001);
        a_addr = 32'd8;  #1; chk("gap_w2", a_instr, 32'hAAAA0002);
        a_addr = 32'd12; #1; chk("gap_untouched", a_instr, 32'h44444444);

        // Reset in the middle of a load
        a_reload = 1'b1; tick(); a_reload = 1'b0;
        send_a(32'hDEAD0001, 1'b0);
        send_a(32'hDEAD0002, 1'b0);
        chk("mid_count_pre", {24'd0, a_wc}, 32'd2);
        a_addr = 32'd0;
        #3 reset = 1'b0;
        #1;
        chk("mid_ready", {31'd0, a_ready}, 32'd0);
        chk("mid_hold",  {31'd0, a_hold},  32'd1);
        chk("mid_error", {31'd0, a_err},   32'd0);
        chk("mid_count", {24'd0, a_wc},    32'd0);
        chk("mid_instr", a_instr,          32'd0);
        tick();
        reset = 1'b1;
        a_valid = 1'b1; a_data = 32'hBEEF0000; a_last = 1'b1;
        tick();
        chk("mid_rel_ready", {31'd0, a_ready}, 32'd1);
        chk("mid_rel_count", {24'd0, a_wc},    32'd0);
        tick();
        a_valid = 1'b0; a_last = 1'b0;
        chk("mid_reload_count", {24'd0, a_wc}, 32'd1);
        chk("mid_reload_hold", {31'd0, a_hold}, 32'd0);
        #1; chk("mid_reload_w0", a_instr, 32'hBEEF0000);
        a_addr = 32'd4; #1; chk("mid_partial_kept", a_instr, 32'hDEAD0002);

        // Overflow on the 8-byte instance (it has been sitting in LOAD)
        b_valid = 1'b1; b_last = 1'b0;
        b_data = 32'hB0000001; tick();
        chk("ovf_count1", {29'd0, b_wc}, 32'd1);
        chk("ovf_err1",   {31'd0, b_err}, 32'd0);
        b_data = 32'hB0000002; tick();
        chk("ovf_count2", {29'd0, b_wc}, 32'd2);
        chk("ovf_err2",   {31'd0, b_err}, 32'd1);
        chk("ovf_ready2", {31'd0, b_ready}, 32'd0);
        chk("ovf_hold2",  {31'd0, b_hold}, 32'd1);
        b_data = 32'hB0000003; tick();
        chk("ovf_count3", {29'd0, b_wc}, 32'd2);
        chk("ovf_err3",   {31'd0, b_err}, 32'd1);
        b_valid = 1'b0;
        b_reload = 1'b1; tick(); b_reload = 1'b0;
        chk("ovf_rel_err",   {31'd0, b_err},   32'd0);
        chk("ovf_rel_ready", {31'd0, b_ready}, 32'd1);
        chk("ovf_rel_count", {29'd0, b_wc},    32'd0);
        chk("ovf_rel_hold",  {31'd0, b_hold},  32'd1);
        // Final slot carrying last goes to DONE
        send_b(32'hC0000001, 1'b0);
        send_b(32'hC0000002, 1'b1);
        chk("slot_err",   {31'd0, b_err},  32'd0);
        chk("slot_hold",  {31'd0, b_hold}, 32'd0);
        chk("slot_count", {29'd0, b_wc},   32'd2);
        b_addr = 32'd0; #1; chk("slot_w0", b_instr, 32'hC0000001);
        b_addr = 32'd4; #1; chk("slot_w1", b_instr, 32'hC0000002);
        b_addr = 32'd5; #1; chk("slot_oob", b_instr, 32'd0);

        // Randomized traffic against the model on both instances
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset(0);
        model_reset(1);
        for (int c = 0; c < 600; c++) begin
            a_valid  = ($urandom_range(0, 9) < 7);
            a_data   = $urandom;
            a_last   = ($urandom_range(0, 30) == 0);
            a_reload = ($urandom_range(0, 15) == 0);
            a_addr   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 406));
            b_valid  = ($urandom_range(0, 9) < 7);
            b_data   = $urandom;
            b_last   = ($urandom_range(0, 4) == 0);
            b_reload = ($urandom_range(0, 7) == 0);
            b_addr   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 10));
            model_edge(0, a_valid, a_data, a_last, a_reload);
            model_edge(1, b_valid, b_data, b_last, b_reload);
            tick();
            model_compare(0, a_addr, a_ready, a_hold, a_err, {24'd0, a_wc}, a_instr);
            model_compare(1, b_addr, b_ready, b_hold, b_err, {29'd0, b_wc}, b_instr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
